// File: rtl/mem_access_unit.sv
// Memory stage: issues one aligned load/store at a time, stalls upstream until mem_ready_i, writes back once.
// Zero-wait accesses, ALU ops and misaligned ops complete in the issuing cycle; waited accesses hold the request in BUSY.
module mem_access_unit #(
  parameter int DATA_WIDTH             = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              validE_i,
  input  logic [DATA_WIDTH-1:0]             ALUResultE_i,
  input  logic [DATA_WIDTH-1:0]             RD2E_i,
  input  logic                              ResultSrcE_i,
  input  logic                              MemWriteE_i,
  input  logic [1:0]                        SizeE_i,
  input  logic                              UnsignedE_i,
  input  logic                              regWriteE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3E_i,
  input  logic                              JALE_i,
  input  logic [DATA_WIDTH-1:0]             incPC5_i,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [DATA_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  output logic [3:0]                        mem_be_o,
  input  logic                              mem_ready_i,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  output logic                              stall_o,
  output logic [DATA_WIDTH-1:0]             ResultW_o,
  output logic                              regWriteW_o,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] AD3W_o,
  output logic                              misalign_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]                        state;
  logic [DATA_WIDTH-1:0]             l_alu, l_wdata, l_link;
  logic [3:0]                        l_be;
  logic [1:0]                        l_size;
  logic                              l_we, l_uns, l_rw, l_jal, l_load;
  logic [REGISTER_ADDRESS_WIDTH-1:0] l_ad3;

  logic                              busy, op, is_load, misal, aligned_op;
  logic [DATA_WIDTH-1:0]             st_wdata, c_alu, c_link, load_val, wb_val;
  logic [3:0]                        st_be;
  logic [1:0]                        c_size;
  logic                              c_uns, c_rw, c_jal, c_load;
  logic [REGISTER_ADDRESS_WIDTH-1:0] c_ad3;

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] rd,
                                                    input logic [1:0] off,
                                                    input logic [1:0] sz,
                                                    input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   extract = uns ? {{(DATA_WIDTH-8){1'b0}}, b} : {{(DATA_WIDTH-8){b[7]}}, b};
      2'b01:   extract = uns ? {{(DATA_WIDTH-16){1'b0}}, h} : {{(DATA_WIDTH-16){h[15]}}, h};
      default: extract = rd;
    endcase
  endfunction

  // A store flagged as a load too is treated purely as a store.
  assign busy       = (state == BUSY);
  assign op         = validE_i & (ResultSrcE_i | MemWriteE_i);
  assign is_load    = ResultSrcE_i & ~MemWriteE_i;
  assign misal      = op & (((SizeE_i == 2'b01) & ALUResultE_i[0]) |
                            (SizeE_i[1] & (ALUResultE_i[1:0] != 2'b00)));
  assign aligned_op = op & ~misal;
  assign mem_req_o  = ~rst & (busy | aligned_op);
  assign stall_o    = mem_req_o & ~mem_ready_i;

  always_comb begin
    case (SizeE_i)
      2'b00: begin
        st_wdata = {(DATA_WIDTH/8){RD2E_i[7:0]}};
        st_be    = 4'b0001 << ALUResultE_i[1:0];
      end
      2'b01: begin
        st_wdata = {(DATA_WIDTH/16){RD2E_i[15:0]}};
        st_be    = 4'b0011 << ALUResultE_i[1:0];
      end
      default: begin
        st_wdata = RD2E_i;
        st_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = 4'b0000;
    if (!rst) begin
      if (busy) begin
        mem_we_o    = l_we;
        mem_addr_o  = {l_alu[DATA_WIDTH-1:2], 2'b00};
        mem_wdata_o = l_wdata;
        mem_be_o    = l_be;
      end else if (aligned_op) begin
        mem_we_o    = MemWriteE_i;
        mem_addr_o  = {ALUResultE_i[DATA_WIDTH-1:2], 2'b00};
        mem_wdata_o = st_wdata;
        mem_be_o    = st_be;
      end
    end
  end

  // Completion uses the latched context in BUSY, the live inputs otherwise.
  assign c_alu    = busy ? l_alu  : ALUResultE_i;
  assign c_link   = busy ? l_link : incPC5_i;
  assign c_size   = busy ? l_size : SizeE_i;
  assign c_uns    = busy ? l_uns  : UnsignedE_i;
  assign c_rw     = busy ? l_rw   : regWriteE_i;
  assign c_jal    = busy ? l_jal  : JALE_i;
  assign c_load   = busy ? l_load : (op & is_load);
  assign c_ad3    = busy ? l_ad3  : AD3E_i;
  assign load_val = extract(mem_rdata_i, c_alu[1:0], c_size, c_uns);
  assign wb_val   = c_jal ? c_link : (c_load ? load_val : c_alu);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      l_alu   <= '0;
      l_wdata <= '0;
      l_link  <= '0;
      l_be    <= 4'b0000;
      l_size  <= 2'b00;
      l_we    <= 1'b0;
      l_uns   <= 1'b0;
      l_rw    <= 1'b0;
      l_jal   <= 1'b0;
      l_load  <= 1'b0;
      l_ad3   <= '0;
    end else if (!busy) begin
      if (aligned_op && !mem_ready_i) begin
        state   <= BUSY;
        l_alu   <= ALUResultE_i;
        l_wdata <= st_wdata;
        l_link  <= incPC5_i;
        l_be    <= st_be;
        l_size  <= SizeE_i;
        l_we    <= MemWriteE_i;
        l_uns   <= UnsignedE_i;
        l_rw    <= regWriteE_i;
        l_jal   <= JALE_i;
        l_load  <= is_load;
        l_ad3   <= AD3E_i;
      end
    end else if (mem_ready_i) begin
      state <= IDLE;
    end
  end

  // Write-back: one update per completed instruction; stalls and bubbles load regWriteW_o=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ResultW_o   <= '0;
      AD3W_o      <= '0;
      regWriteW_o <= 1'b0;
      misalign_o  <= 1'b0;
    end else if (!stall_o && (busy || validE_i)) begin
      ResultW_o   <= wb_val;
      AD3W_o      <= c_ad3;
      regWriteW_o <= c_rw & ~(~busy & misal);
      misalign_o  <= ~busy & misal;
    end else begin
      regWriteW_o <= 1'b0;
      misalign_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a byte-array memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        validE_i, ResultSrcE_i, MemWriteE_i, UnsignedE_i, regWriteE_i, JALE_i;
  logic [31:0] ALUResultE_i, RD2E_i, incPC5_i, mem_rdata_i;
  logic [1:0]  SizeE_i;
  logic [4:0]  AD3E_i;
  logic        mem_req_o, mem_we_o, mem_ready_i, stall_o, regWriteW_o, misalign_o;
  logic [31:0] mem_addr_o, mem_wdata_o, ResultW_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  AD3W_o;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .validE_i(validE_i), .ALUResultE_i(ALUResultE_i), .RD2E_i(RD2E_i),
    .ResultSrcE_i(ResultSrcE_i), .MemWriteE_i(MemWriteE_i), .SizeE_i(SizeE_i),
    .UnsignedE_i(UnsignedE_i), .regWriteE_i(regWriteE_i), .AD3E_i(AD3E_i), .JALE_i(JALE_i),
    .incPC5_i(incPC5_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .ResultW_o(ResultW_o),
    .regWriteW_o(regWriteW_o), .AD3W_o(AD3W_o), .misalign_o(misalign_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          d;
  } req_t;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  ad3;
  } wb_t;

  req_t       rq[$];
  wb_t        wq[$];
  int         mis_pend = 0;
  int         scnt = 0;
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mb [0:1023];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  function automatic logic [31:0] word_at(input int b);
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  task automatic set_word(input int b, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mb[b+i] = w[8*i +: 8];
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mem_req_o) begin
        if (rq.size() == 0) begin
          fail("req_unexpected");
        end else if (!mem_ready_i) begin
          scnt++;
          chk("stall_wait", {31'b0, stall_o}, 32'd1);
        end else begin
          req_t e;
          e = rq.pop_front();
          chk("req_addr", mem_addr_o, e.addr);
          chk("req_we", {31'b0, mem_we_o}, {31'b0, e.we});
          chk("req_be", {28'b0, mem_be_o}, {28'b0, e.be});
          if (e.we) chk("req_wdata", mem_wdata_o, e.wdata);
          chk("stall_done", {31'b0, stall_o}, 32'd0);
          chk("stall_cycles", scnt, e.d);
          scnt = 0;
        end
      end
      if (regWriteW_o) begin
        if (wq.size() == 0) begin
          fail("wb_unexpected");
        end else begin
          wb_t w;
          w = wq.pop_front();
          chk("wb_result", ResultW_o, w.result);
          chk("wb_ad3", {27'b0, AD3W_o}, {27'b0, w.ad3});
        end
      end
      if (misalign_o) begin
        if (mis_pend == 0) fail("misalign_unexpected");
        else begin
          mis_pend--;
          total++;
        end
      end
    end
  end

  task automatic issue(input bit v, input bit ld, input bit st, input logic [1:0] sz,
                       input bit uns, input bit rw, input bit jal, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [31:0] link, input logic [4:0] ad3,
                       input int d);
    bit          op, is_ld, mis;
    int          n, off, base;
    logic [31:0] val, mask, rword;
    req_t        r;
    wb_t         w;
    op    = v && (ld || st);
    is_ld = ld && !st;
    n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off   = int'(alu[1:0]);
    base  = int'(alu[9:2]) * 4;
    mis   = op && ((n == 2 && alu[0]) || (n == 4 && alu[1:0] != 2'b00));
    val   = 32'h0;
    rword = 32'($urandom);
    if (op && !mis) begin
      rword   = word_at(base);
      r.addr  = {alu[31:2], 2'b00};
      r.we    = st;
      r.be    = 4'b0000;
      r.wdata = 32'h0;
      r.d     = d;
      for (int i = 0; i < n; i++) r.be[off+i] = 1'b1;
      for (int l = 0; l < 4; l++) r.wdata[8*l +: 8] = rd2[8*(l % n) +: 8];
      rq.push_back(r);
      for (int i = 0; i < n; i++) val = val | (32'(mb[base+off+i]) << (8*i));
      if (n < 4 && !uns && val[8*n-1]) begin
        mask = (32'd1 << (8*n)) - 32'd1;
        val  = val | ~mask;
      end
      if (st) for (int i = 0; i < n; i++) mb[base+off+i] = rd2[8*i +: 8];
    end
    if (mis) mis_pend++;
    if (v && rw && !mis) begin
      w.result = jal ? link : ((op && is_ld) ? val : alu);
      w.ad3    = ad3;
      wq.push_back(w);
    end
    @(posedge clk); #1;
    validE_i = v; ResultSrcE_i = ld; MemWriteE_i = st; SizeE_i = sz; UnsignedE_i = uns;
    regWriteE_i = rw; JALE_i = jal; ALUResultE_i = alu; RD2E_i = rd2; incPC5_i = link;
    AD3E_i = ad3; mem_rdata_i = rword;
    mem_ready_i = (op && !mis) ? (d == 0) : 1'($urandom);
    if (op && !mis) begin
      for (int k = 1; k <= d; k++) begin
        @(posedge clk); #1;
        ALUResultE_i = 32'($urandom); RD2E_i = 32'($urandom); SizeE_i = 2'($urandom);
        UnsignedE_i = 1'($urandom); AD3E_i = 5'($urandom); JALE_i = 1'($urandom);
        mem_ready_i = (k == d);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; validE_i = 1'b0; ResultSrcE_i = 1'b0; MemWriteE_i = 1'b0; SizeE_i = 2'b00;
    UnsignedE_i = 1'b0; regWriteE_i = 1'b0; JALE_i = 1'b0; ALUResultE_i = 32'h0;
    RD2E_i = 32'h0; incPC5_i = 32'h0; AD3E_i = 5'h0; mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    for (int i = 0; i < 1024; i++) mb[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
    chk("rst_regwrite", {31'b0, regWriteW_o}, 32'd0);
    chk("rst_result", ResultW_o, 32'h0);
    chk("rst_ad3", {27'b0, AD3W_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_be", {28'b0, mem_be_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    set_word(32'h100, 32'hDEADBEEF);
    issue(1, 1, 0, 2'b10, 0, 1, 0, 32'h100, 32'h0, 32'h0, 5'd3, 3);
    set_word(32'h100, 32'h80112233);
    issue(1, 1, 0, 2'b00, 0, 1, 0, 32'h103, 32'h0, 32'h0, 5'd4, 0);
    issue(1, 1, 0, 2'b00, 1, 1, 0, 32'h103, 32'h0, 32'h0, 5'd5, 0);
    issue(1, 0, 1, 2'b01, 0, 0, 0, 32'h202, 32'h0000ABCD, 32'h0, 5'd0, 1);
    issue(1, 1, 0, 2'b10, 0, 1, 0, 32'h101, 32'h0, 32'h0, 5'd6, 0);
    issue(1, 0, 0, 2'b00, 0, 1, 1, 32'h1234, 32'h0, 32'h44, 5'd1, 0);
    issue(1, 0, 0, 2'b00, 0, 1, 0, 32'h7, 32'h0, 32'h0, 5'd2, 0);
    issue(1, 1, 1, 2'b11, 0, 1, 0, 32'h30C, 32'h5555AAAA, 32'h0, 5'd7, 2);
    issue(0, 1, 0, 2'b10, 0, 1, 0, 32'h100, 32'h0, 32'h0, 5'd8, 0);

    for (int t = 0; t < 400; t++) begin
      int          kind;
      bit          v, ld, st, jal;
      logic [31:0] alu;
      kind = int'($urandom_range(0, 3));
      v    = ($urandom_range(0, 7) != 0);
      ld   = (kind == 0) || (kind == 3);
      st   = (kind == 1) || (kind == 3);
      jal  = (kind == 2) && ($urandom_range(0, 3) == 0);
      alu  = (ld || st) ? 32'($urandom_range(0, 1023)) : 32'($urandom);
      issue(v, ld, st, 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), jal, alu,
            32'($urandom), 32'($urandom), 5'($urandom), int'($urandom_range(0, 3)));
    end
    repeat (3) issue(0, 0, 0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0);
    @(negedge clk);
    chk("end_req_queue", rq.size(), 0);
    chk("end_wb_queue", wq.size(), 0);
    chk("end_misalign_pending", mis_pend, 0);
    mon_en = 1'b0;

    // Reset landing in the second BUSY cycle abandons the access.
    @(posedge clk); #1;
    validE_i = 1'b1; ResultSrcE_i = 1'b1; MemWriteE_i = 1'b0; SizeE_i = 2'b10;
    regWriteE_i = 1'b1; JALE_i = 1'b0; ALUResultE_i = 32'h200; mem_ready_i = 1'b0;
    @(posedge clk); #1;
    validE_i = 1'b0;
    @(negedge clk);
    chk("rst_busy_stall", {31'b0, stall_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_req", {31'b0, mem_req_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("post_rst_stall", {31'b0, stall_o}, 32'd0);
    chk("post_rst_regwrite", {31'b0, regWriteW_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_no_wb", {31'b0, regWriteW_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: DATA_WIDTH, default 32, datapath width; REGISTER_ADDRESS_WIDTH, default 5, destination register index width.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 validE_i  in  1  memory-stage slot holds a live instruction.
REQ-005 ALUResultE_i  in  DATA_WIDTH  effective address, or result for non-memory ops.
REQ-006 RD2E_i  in  DATA_WIDTH  store data.
REQ-007 ResultSrcE_i  in  1  instruction is a load; MemWriteE_i  in  1  instruction is a store.
REQ-008 SizeE_i  in  2  access size: 00 byte, 01 half, 10 word; 11 SHALL be treated as word. UnsignedE_i  in  1  zero-extend loads.
REQ-009 regWriteE_i  in  1; AD3E_i  in  REGISTER_ADDRESS_WIDTH; JALE_i  in  1; incPC5_i  in  DATA_WIDTH  link value.
REQ-010 mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  DATA_WIDTH  word-aligned, bits[1:0]=00; mem_wdata_o  out  DATA_WIDTH  lane-shifted; mem_be_o  out  4  byte enables.
REQ-011 mem_ready_i  in  1  completes the current request; mem_rdata_i  in  DATA_WIDTH  valid when mem_ready_i=1 on a read.
REQ-012 stall_o  out  1  when high, upstream pipeline registers SHALL hold (drives their enable low).
REQ-013 ResultW_o  out  DATA_WIDTH; regWriteW_o  out  1; AD3W_o  out  REGISTER_ADDRESS_WIDTH; misalign_o  out  1  single-cycle fault pulse.

Function
REQ-014 Two-state FSM, IDLE and BUSY; op = validE_i & (ResultSrcE_i | MemWriteE_i); if both set, store SHALL win and the write-back value SHALL be ALUResultE_i.
REQ-015 Misaligned = half with addr[0]=1, or word with addr[1:0]!=00; a misaligned op SHALL issue no request, SHALL pulse misalign_o for one cycle, and SHALL write back with regWriteW_o=0.
REQ-016 IDLE with aligned op: mem_req_o SHALL assert combinationally the same cycle; if mem_ready_i=1, complete this cycle and stay IDLE; else latch address, wdata, be, we, size, unsigned, regWrite, AD3 and go to BUSY.
REQ-017 BUSY: mem_req_o and all mem_* outputs SHALL hold the latched values; on mem_ready_i=1, complete and return to IDLE.
REQ-018 stall_o = (IDLE & aligned op & !mem_ready_i) | (BUSY & !mem_ready_i); stall_o SHALL be 0 in the completing cycle.
REQ-019 Store lanes: byte, data[7:0] replicated to all lanes, be=0001<<addr[1:0]; half, data[15:0] replicated, be=0011<<addr[1:0]; word, be=1111.
REQ-020 Load extraction: select byte/half by the latched addr[1:0], then sign-extend, or zero-extend if unsigned; word SHALL pass mem_rdata_i unchanged.
REQ-021 Write-back register SHALL update once per completed instruction, on the completing edge: ResultW_o = incPC5 if JAL, else the extracted load data if load, else ALUResult; regWriteW_o = regWrite & !misaligned; AD3W_o = AD3.
REQ-022 Non-memory valid instruction SHALL complete in 1 cycle with no request; when validE_i=0 the write-back register SHALL load regWriteW_o=0 (bubble).
REQ-023 While stalled, ResultW_o/AD3W_o SHALL hold and regWriteW_o SHALL be 0, so no instruction writes back twice.
REQ-024 Inputs are ignored in BUSY; latency from request to write-back = number of cycles until mem_ready_i, minimum 1 edge.
REQ-025 mem_ready_i while mem_req_o=0 SHALL be ignored.

Reset
REQ-026 While rst=1: state IDLE; mem_req_o, mem_we_o, stall_o, misalign_o, regWriteW_o = 0; ResultW_o, AD3W_o, mem_addr_o, mem_wdata_o, mem_be_o = 0.
REQ-027 Reset asserted in BUSY SHALL abandon the transaction, with no write-back, and mem_req_o SHALL be low during the reset cycle.

Verification
REQ-028 Load word at 0x100, mem_ready_i high 3 cycles after request, rdata 0xDEADBEEF -> stall_o high 3 cycles, then ResultW_o=0xDEADBEEF, regWriteW_o=1 for exactly one cycle.
REQ-029 Signed byte load at 0x103, rdata 0x80112233, immediate ready -> ResultW_o=0xFFFFFF80, stall_o=0; with UnsignedE_i=1 -> 0x00000080.
REQ-030 Store half 0x0000ABCD at 0x202 -> mem_addr_o=0x200, mem_be_o=1100, mem_wdata_o=0xABCDABCD, mem_we_o=1, regWriteW_o=0.
REQ-031 Word load at 0x101 -> mem_req_o stays 0, misalign_o one-cycle pulse, regWriteW_o=0, stall_o=0.
REQ-032 JAL with incPC5_i=0x44, then an ALU op with result 0x7 -> ResultW_o=0x44, then 0x7, on consecutive cycles, with no requests.
REQ-033 rst asserted in the 2nd BUSY cycle, mem_ready_i held low -> next cycle IDLE, mem_req_o=0, stall_o=0, regWriteW_o=0.
